// File: rtl/game_clock_if.sv
// Scoreboard-facing signal bundle for the game-clock controller: buttons in,
// display and status fields out.
interface game_clock_if;
  logic       btn_start;
  logic       btn_shot;
  logic       next_quarter;
  logic [3:0] time_min;
  logic [5:0] time_sec;
  logic [4:0] shot_sec;
  logic [2:0] quarter;
  logic       running;
  logic       buzzer;
  logic       game_over;

  modport master (
    output btn_start, btn_shot, next_quarter,
    input  time_min, time_sec, shot_sec, quarter, running, buzzer, game_over
  );

  modport slave (
    input  btn_start, btn_shot, next_quarter,
    output time_min, time_sec, shot_sec, quarter, running, buzzer, game_over
  );
endinterface

// File: rtl/game_clock_ctrl.sv
// Basketball game clock: 1 Hz prescaler, quarter/shot countdown, quarter sequencing, buzzer.
// Define SHOT_CLOCK_EN to build the 24 s shot clock; without it shot_sec is tied to 0.
//
// state    | meaning
// IDLE     | quarter loaded, clock stopped, waiting for start
// RUNNING  | prescaler counting, countdown active
// PAUSED   | stopped mid-quarter, prescaler fraction held
// QEND     | quarter time expired, waiting for next_quarter
// GOVER    | final quarter expired, only reset leaves
module game_clock_ctrl #(
  parameter int unsigned CLK_HZ       = 50000000,
  parameter int unsigned QUARTER_SEC  = 600,
  parameter int unsigned SHOT_SEC     = 24,
  parameter int unsigned NUM_QUARTERS = 4,
  parameter int unsigned BUZZ_CYCLES  = 100000000
) (
  input logic         clock_in,
  input logic         reset_n,
  game_clock_if.slave bus
);

  localparam int unsigned PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int unsigned BW = $clog2(BUZZ_CYCLES + 1);

  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_HZ - 1);
  localparam logic [3:0]    Q_MIN     = 4'(QUARTER_SEC / 60);
  localparam logic [5:0]    Q_SEC     = 6'(QUARTER_SEC % 60);
  localparam logic [2:0]    NQ        = 3'(NUM_QUARTERS);
  localparam logic [BW-1:0] BUZZ_RLD  = BW'(BUZZ_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RUNNING = 3'd1,
    S_PAUSED  = 3'd2,
    S_QEND    = 3'd3,
    S_GOVER   = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [3:0]    min_q, min_d;
  logic [5:0]    sec_q, sec_d;
  logic [2:0]    quarter_q, quarter_d;
  logic [BW-1:0] buzz_q, buzz_d;
  logic          running_q, running_d;
  logic          buzzer_q, buzzer_d;
  logic          game_over_q, game_over_d;

  logic tick;
  logic game_exp;
  logic shot_exp;
  logic start_ok;
  logic new_quarter;

  assign tick        = (state_q == S_RUNNING) && (presc_q == PRESC_MAX);
  // 0:01 is the last second; the <= also keeps a stray 0:00 from wrapping
  assign game_exp    = tick && (min_q == 4'd0) && (sec_q <= 6'd1);
  assign new_quarter = (state_q == S_QEND) && bus.next_quarter;

`ifdef SHOT_CLOCK_EN
  localparam logic [4:0] SHOT_RLD = 5'(SHOT_SEC);

  logic [4:0] shot_q, shot_d;
  logic       shot_reload;

  assign shot_reload = bus.btn_shot &&
                       (state_q inside {S_IDLE, S_RUNNING, S_PAUSED});
  assign shot_exp    = tick && !shot_reload && !game_exp && (shot_q == 5'd1);
  assign start_ok    = (shot_q != 5'd0);

  always_comb begin
    shot_d = shot_q;
    if (shot_reload || new_quarter) begin
      shot_d = SHOT_RLD;
    end else if (tick && (shot_q != 5'd0)) begin
      shot_d = shot_q - 5'd1;
    end
  end

  always_ff @(posedge clock_in) begin
    if (!reset_n) begin
      shot_q <= SHOT_RLD;
    end else begin
      shot_q <= shot_d;
    end
  end

  assign bus.shot_sec = shot_q;
`else
  logic unused_btn_shot;

  assign unused_btn_shot = bus.btn_shot;
  assign shot_exp        = 1'b0;
  assign start_ok        = 1'b1;
  assign bus.shot_sec    = 5'd0;
`endif

  always_ff @(posedge clock_in) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (bus.btn_start) state_d = S_RUNNING;
      end
      S_RUNNING: begin
        if (game_exp) begin
          state_d = (quarter_q < NQ) ? S_QEND : S_GOVER;
        end else if (shot_exp || bus.btn_start) begin
          state_d = S_PAUSED;
        end
      end
      S_PAUSED: begin
        if (bus.btn_start && start_ok) state_d = S_RUNNING;
      end
      S_QEND: begin
        if (bus.next_quarter) state_d = S_IDLE;
      end
      S_GOVER: begin
        state_d = S_GOVER;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    running_d   = (state_d == S_RUNNING);
    game_over_d = (state_d == S_GOVER);
    buzzer_d    = (buzz_d != '0);
  end

  always_comb begin
    presc_d   = presc_q;
    min_d     = min_q;
    sec_d     = sec_q;
    quarter_d = quarter_q;
    buzz_d    = buzz_q;

    if (state_q == S_RUNNING) begin
      presc_d = tick ? '0 : presc_q + PW'(1);
    end

    if (tick) begin
      if (sec_q != 6'd0) begin
        sec_d = sec_q - 6'd1;
      end else if (min_q != 4'd0) begin
        min_d = min_q - 4'd1;
        sec_d = 6'd59;
      end
    end

    if (new_quarter) begin
      quarter_d = quarter_q + 3'd1;
      min_d     = Q_MIN;
      sec_d     = Q_SEC;
      presc_d   = '0;
    end

    // a fresh expiry retriggers the full pulse even if one is in progress
    if (game_exp || shot_exp) begin
      buzz_d = BUZZ_RLD;
    end else if (buzz_q != '0) begin
      buzz_d = buzz_q - BW'(1);
    end
  end

  always_ff @(posedge clock_in) begin
    if (!reset_n) begin
      presc_q     <= '0;
      min_q       <= Q_MIN;
      sec_q       <= Q_SEC;
      quarter_q   <= 3'd1;
      buzz_q      <= '0;
      running_q   <= 1'b0;
      buzzer_q    <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      presc_q     <= presc_d;
      min_q       <= min_d;
      sec_q       <= sec_d;
      quarter_q   <= quarter_d;
      buzz_q      <= buzz_d;
      running_q   <= running_d;
      buzzer_q    <= buzzer_d;
      game_over_q <= game_over_d;
    end
  end

  assign bus.time_min  = min_q;
  assign bus.time_sec  = sec_q;
  assign bus.quarter   = quarter_q;
  assign bus.running   = running_q;
  assign bus.buzzer    = buzzer_q;
  assign bus.game_over = game_over_q;

endmodule

// File: tb/tb_game_clock_ctrl.sv
// Directed bench for game_clock_ctrl with a 10-cycle second, 65 s quarters, 5 s shot clock.
// Shot-clock expectations follow SHOT_CLOCK_EN as seen by the RTL.
module tb_game_clock_ctrl;

`ifdef SHOT_CLOCK_EN
  localparam bit SHOT_EN = 1'b1;
`else
  localparam bit SHOT_EN = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   total;
  int   passed;

  game_clock_if gif ();

  game_clock_ctrl #(
    .CLK_HZ      (10),
    .QUARTER_SEC (65),
    .SHOT_SEC    (5),
    .NUM_QUARTERS(2),
    .BUZZ_CYCLES (3)
  ) dut (
    .clock_in(clk),
    .reset_n (rst_n),
    .bus     (gif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic press_start();
    gif.btn_start = 1'b1;
    cyc(1);
    gif.btn_start = 1'b0;
  endtask

  task automatic press_shot();
    gif.btn_shot = 1'b1;
    cyc(1);
    gif.btn_shot = 1'b0;
  endtask

  task automatic press_next();
    gif.next_quarter = 1'b1;
    cyc(1);
    gif.next_quarter = 1'b0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_min"},  gif.time_min, 1);
    chk({tag, "_sec"},  gif.time_sec, 5);
    chk({tag, "_shot"}, gif.shot_sec, SHOT_EN ? 5 : 0);
    chk({tag, "_qtr"},  gif.quarter, 1);
    chk({tag, "_run"},  gif.running, 0);
    chk({tag, "_buzz"}, gif.buzzer, 0);
    chk({tag, "_gov"},  gif.game_over, 0);
  endtask

  initial begin
    total = 0;
    passed = 0;
    rst_n = 1'b0;
    gif.btn_start = 1'b0;
    gif.btn_shot = 1'b0;
    gif.next_quarter = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    chk_reset_state("rst");

    // start at E0; first decrement lands at E10
    press_start();
    chk("start_run", gif.running, 1);
    cyc(9);
    chk("pre_tick_sec", gif.time_sec, 5);
    cyc(1);
    chk("tick1_min", gif.time_min, 1);
    chk("tick1_sec", gif.time_sec, 4);
    chk("tick1_shot", gif.shot_sec, SHOT_EN ? 4 : 0);

    // pause at E15 with 5/10 of a second banked, resume at E35
    cyc(4);
    press_start();
    chk("pause_run", gif.running, 0);
    cyc(19);
    chk("paused_sec", gif.time_sec, 4);
    press_start();
    chk("resume_run", gif.running, 1);
    cyc(4);
    chk("resume_early_sec", gif.time_sec, 4);
    cyc(1);
    chk("resume_tick_sec", gif.time_sec, 3);
    chk("resume_tick_shot", gif.shot_sec, SHOT_EN ? 3 : 0);

`ifdef SHOT_CLOCK_EN
    cyc(29);
    chk("shot1_shot", gif.shot_sec, 1);
    chk("shot1_run", gif.running, 1);
    cyc(1);
    chk("shotexp_run", gif.running, 0);
    chk("shotexp_shot", gif.shot_sec, 0);
    chk("shotexp_buzz", gif.buzzer, 1);
    chk("shotexp_sec", gif.time_sec, 0);
    chk("shotexp_min", gif.time_min, 1);
    press_start();
    chk("inhibit_run", gif.running, 0);
    chk("shotbuzz_c2", gif.buzzer, 1);
    cyc(1);
    chk("shotbuzz_c3", gif.buzzer, 1);
    cyc(1);
    chk("shotbuzz_end", gif.buzzer, 0);
    press_shot();
    chk("reload_shot", gif.shot_sec, 5);
    press_start();
    chk("rerun_run", gif.running, 1);

    cyc(40);
    chk("pre_race_shot", gif.shot_sec, 1);
    chk("pre_race_sec", gif.time_sec, 56);
    chk("pre_race_min", gif.time_min, 0);
    cyc(9);
    gif.btn_shot = 1'b1;
    cyc(1);
    gif.btn_shot = 1'b0;
    chk("race_shot", gif.shot_sec, 5);
    chk("race_sec", gif.time_sec, 55);
    chk("race_run", gif.running, 1);
    chk("race_buzz", gif.buzzer, 0);

    for (int i = 0; i < 13; i++) begin
      cyc(39);
      press_shot();
    end
    chk("q1_late_sec", gif.time_sec, 3);
    chk("q1_late_run", gif.running, 1);
    cyc(29);
    chk("q1_last_sec", gif.time_sec, 1);
    chk("q1_last_run", gif.running, 1);
    cyc(1);
    chk("q1_end_shot", gif.shot_sec, 2);
`else
    cyc(629);
    chk("q1_last_sec", gif.time_sec, 1);
    chk("q1_last_min", gif.time_min, 0);
    chk("q1_last_run", gif.running, 1);
    cyc(1);
    chk("q1_end_shot", gif.shot_sec, 0);
`endif

    chk("q1_end_min", gif.time_min, 0);
    chk("q1_end_sec", gif.time_sec, 0);
    chk("q1_end_run", gif.running, 0);
    chk("q1_end_buzz", gif.buzzer, 1);
    chk("q1_end_gov", gif.game_over, 0);
    chk("q1_end_qtr", gif.quarter, 1);
    cyc(2);
    chk("q1_buzz_c3", gif.buzzer, 1);
    cyc(1);
    chk("q1_buzz_end", gif.buzzer, 0);

    press_start();
    chk("qend_start_ign", gif.running, 0);
    press_shot();
    chk("qend_shot_ign", gif.shot_sec, SHOT_EN ? 2 : 0);
    press_next();
    chk("q2_qtr", gif.quarter, 2);
    chk("q2_min", gif.time_min, 1);
    chk("q2_sec", gif.time_sec, 5);
    chk("q2_shot", gif.shot_sec, SHOT_EN ? 5 : 0);
    chk("q2_run", gif.running, 0);
    chk("q2_buzz", gif.buzzer, 0);

    // quarter 2: shot reloads every 4 s keep the shot clock from expiring
    press_start();
    chk("q2_start_run", gif.running, 1);
    for (int i = 0; i < 16; i++) begin
      cyc(39);
      press_shot();
    end
    chk("q2_last_sec", gif.time_sec, 1);
    chk("q2_last_min", gif.time_min, 0);
    chk("q2_last_run", gif.running, 1);
    cyc(10);
    chk("go_gov", gif.game_over, 1);
    chk("go_run", gif.running, 0);
    chk("go_buzz", gif.buzzer, 1);
    chk("go_sec", gif.time_sec, 0);
    chk("go_shot", gif.shot_sec, SHOT_EN ? 4 : 0);
    chk("go_qtr", gif.quarter, 2);

    gif.btn_start = 1'b1;
    gif.btn_shot = 1'b1;
    gif.next_quarter = 1'b1;
    cyc(1);
    gif.btn_start = 1'b0;
    gif.btn_shot = 1'b0;
    gif.next_quarter = 1'b0;
    chk("go_ign_run", gif.running, 0);
    chk("go_ign_gov", gif.game_over, 1);
    chk("go_ign_shot", gif.shot_sec, SHOT_EN ? 4 : 0);
    chk("go_ign_qtr", gif.quarter, 2);
    chk("go_buzz_c2", gif.buzzer, 1);

    // reset lands while the buzzer still has a cycle to go
    rst_n = 1'b0;
    cyc(1);
    chk_reset_state("midrst");
    rst_n = 1'b1;
    press_start();
    chk("post_rst_run", gif.running, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
